// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and line levels
// used by both the transmit and receive stages.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer (master) and the UART
// transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample counter: bit_tick pulses on the last cycle of each bit period.
// Cleared at frame start so every frame begins on a fresh bit boundary.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 8
) (
    input  logic baud_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic    baud_clk,
    input  logic    reset,
    uart_tx_if.slave tx_if,
    output logic    dout,
    output logic    tx_busy,
    output logic    tx_done
);

    localparam int STOP_W = 1;
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
    logic                 dout_q, dout_d;
    logic                 timer_clear;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .baud_clk (baud_clk),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (tx_busy),
        .bit_tick (bit_tick)
    );

    assign tx_if.tx_ready = (state_q == ST_IDLE);
    assign tx_busy        = (state_q != ST_IDLE);
    assign dout           = dout_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        timer_clear = 1'b0;
        tx_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_if.tx_valid) begin
                    shift_d     = tx_if.tx_data;
                    bit_idx_d   = '0;
                    stop_cnt_d  = '0;
                    timer_clear = 1'b1;
                    state_d     = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d    = even_parity(tx_if.tx_data);
`endif
                end
            end
            ST_START: begin
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // dout is registered, so it follows the state being entered
        dout_d = LINE_IDLE;
        case (state_d)
            ST_START:  dout_d = START_LEVEL;
            ST_DATA:   dout_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: dout_d = parity_d;
`endif
            ST_STOP:   dout_d = STOP_LEVEL;
            default:   dout_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
            dout_q     <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            dout_q     <= dout_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (defaults, and OVERSAMPLE=4/STOP_BITS=2),
// each frame compared cycle by cycle against a bit-list model of the frame.
module tb_uart_tx;

    logic       clk;
    logic       reset_n;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       sel;

    logic dout_a, busy_a, done_a;
    logic dout_b, busy_b, done_b;
    logic mon_dout, mon_busy, mon_done, mon_ready;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_if if_a ();
    uart_tx_if if_b ();

    assign if_a.tx_data  = drv_data;
    assign if_a.tx_valid = drv_valid && !sel;
    assign if_b.tx_data  = drv_data;
    assign if_b.tx_valid = drv_valid && sel;

    uart_tx #(.OVERSAMPLE(8), .STOP_BITS(1)) dut_a (
        .baud_clk (clk),
        .reset    (reset_n),
        .tx_if    (if_a.slave),
        .dout     (dout_a),
        .tx_busy  (busy_a),
        .tx_done  (done_a)
    );

    uart_tx #(.OVERSAMPLE(4), .STOP_BITS(2)) dut_b (
        .baud_clk (clk),
        .reset    (reset_n),
        .tx_if    (if_b.slave),
        .dout     (dout_b),
        .tx_busy  (busy_b),
        .tx_done  (done_b)
    );

    assign mon_dout  = sel ? dout_b : dout_a;
    assign mon_busy  = sel ? busy_b : busy_a;
    assign mon_done  = sel ? done_b : done_a;
    assign mon_ready = sel ? if_b.tx_ready : if_a.tx_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called on a negedge with the selected DUT idle. Sends d and checks
    // every cycle of the frame; abort_at>0 resets the DUT at that cycle.
    task automatic run_frame(input logic [7:0] d, input bit hold, input int abort_at);
        int   os, sb, len;
        logic exp_q[$];
        bit   aborted;
        aborted = 0;
        os = sel ? 4 : 8;
        sb = sel ? 2 : 1;
        repeat (os) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (os) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        repeat (os) exp_q.push_back(^d);
`endif
        repeat (sb * os) exp_q.push_back(1'b1);
        len = exp_q.size();

        check_eq("idle_ready", mon_ready, 1);
        check_eq("idle_dout", mon_dout, 1);
        check_eq("idle_busy", mon_busy, 0);
        check_eq("idle_done", mon_done, 0);
        drv_data  = d;
        drv_valid = 1'b1;

        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (!hold) drv_valid = 1'b0;
            if (c == len / 2) drv_data = 8'($urandom);
            check_eq($sformatf("dout[c%0d]", c), mon_dout, exp_q[c-1]);
            check_eq($sformatf("done[c%0d]", c), mon_done, (c == len) ? 1 : 0);
            check_eq($sformatf("busy[c%0d]", c), mon_busy, 1);
            check_eq($sformatf("ready[c%0d]", c), mon_ready, 0);
            if (c == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_eq("abort_dout", mon_dout, 1);
                check_eq("abort_busy", mon_busy, 0);
                check_eq("abort_ready", mon_ready, 1);
                check_eq("abort_done", mon_done, 0);
                @(negedge clk);
                check_eq("abort_hold_done", mon_done, 0);
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
        end
        $display("frame dut=%s data=%02h len=%0d hold=%0d%s", sel ? "B" : "A", d, len,
                 hold, aborted ? " aborted" : "");
        @(negedge clk);
    endtask

    initial begin
        bit h;
        reset_n   = 1'b0;
        drv_valid = 1'b0;
        drv_data  = 8'h00;
        sel       = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dout_a", dout_a, 1);
        check_eq("rst_ready_a", if_a.tx_ready, 1);
        check_eq("rst_busy_a", busy_a, 0);
        check_eq("rst_done_a", done_a, 0);
        check_eq("rst_dout_b", dout_b, 1);
        check_eq("rst_ready_b", if_b.tx_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(8'h55, 0, 0);
        run_frame(8'h00, 0, 0);
        repeat (2) @(negedge clk);
        run_frame(8'hA5, 1, 0);
        run_frame(8'h3C, 0, 0);
        run_frame(8'h0F, 0, 30);
        run_frame(8'h81, 0, 0);
        run_frame(8'h07, 0, 0);
        run_frame(8'h03, 0, 0);
        for (int i = 0; i < 20; i++) begin
            h = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_frame(8'($urandom), h, 0);
            if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        sel = 1'b1;
        @(negedge clk);
        run_frame(8'hC3, 0, 0);
        for (int i = 0; i < 10; i++) begin
            h = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_frame(8'($urandom), h, 0);
            if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        run_frame(8'h5A, 0, 13);
        run_frame(8'h96, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART path: accepts a byte over a valid/ready handshake and drives it onto the serial line as an 8N1 frame (start bit, 8 data bits LSB first, stop bit). It sits directly upstream of the UART receive stage, whose serial input it drives. Both use the same oversampled `baud_clk`, so each bit is held for `OVERSAMPLE` clock cycles.

## Interface
- `OVERSAMPLE`, default 8: `baud_clk` cycles per bit; legal range 2..16.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

Ports:
- `baud_clk` in 1: sole clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send; sampled only on handshake.
- `tx_valid` in 1: the upstream producer has a byte.
- `tx_ready` out 1: the block can accept a byte; high only in IDLE.
- `dout` out 1: serial line; idles high; registered output.
- `tx_busy` out 1: a frame is in progress (any state except IDLE).
- `tx_done` out 1: one-cycle pulse when the final stop bit completes.

## Operation
States: IDLE, START, DATA, PARITY (present only with the macro), STOP.

- **IDLE:** `dout`=1, `tx_ready`=1.
  - On `tx_valid && tx_ready`: latch `tx_data` into the shift register, clear the bit counters, go to START.
- **START:** `dout`=0 for `OVERSAMPLE` cycles, then go to DATA.
- **DATA:** `dout`=shift[0]. Each bit is held `OVERSAMPLE` cycles, then the register shifts right.
  - After bit 7, go to PARITY if the macro is enabled, otherwise STOP.
- **PARITY:** `dout`=even parity (XOR of the latched byte) for `OVERSAMPLE` cycles, then go to STOP.
- **STOP:** `dout`=1 for `STOP_BITS*OVERSAMPLE` cycles.
  - In the last cycle: assert `tx_done` and go to IDLE.

Width and arithmetic rules:
- Oversample counter is `$clog2(OVERSAMPLE)` bits; it counts 0..OVERSAMPLE-1 and wraps to 0 on each bit boundary.
- Data bit index is 3 bits (0..7).
- Stop counter counts 0..STOP_BITS-1.

Boundary conditions:
- `tx_valid` outside IDLE is ignored; there is no queueing. The producer holds `tx_valid` until it sees the handshake.
- Changes on `tx_data` after the handshake do not affect the frame in flight.
- `reset` asserted mid-frame: outputs immediately take their reset values, the frame is abandoned, and no `tx_done` is produced.
- Deassertion of `tx_valid` mid-frame has no effect.

## Timing
- Reset values: `dout`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, counters and shift register=0.
- Handshake in cycle N: `dout` falls at N+1. `tx_ready` and `tx_busy` change at N+1.
- Each bit is held exactly `OVERSAMPLE` cycles.
- Frame length is (10 + parity + STOP_BITS-1) × OVERSAMPLE cycles, counted from the first start-bit cycle.
- `tx_done` is high during the last STOP cycle. `tx_ready` returns to 1 in the following cycle.
- Back-to-back: with `tx_valid` held high, the next handshake happens in the first IDLE cycle. The line therefore stays high for `STOP_BITS*OVERSAMPLE`+1 cycles between frames.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - An even-parity bit is inserted between bit 7 and the stop bit.
  - With defaults, the frame is 11 × 8 = 88 cycles.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Plain 8N1 frame; with defaults, 80 cycles.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - `DATA_BITS`=8;
  - line idle level, start level and stop level constants.
- These constants are shared with the receive stage.
- One natural sub-module, `uart_bit_timer`:
  - an oversample counter with a `bit_tick` output, pulsed when the count reaches OVERSAMPLE-1;
  - cleared on frame start;
  - reusable by the receiver.

## Test plan
- Reset, then `tx_data`=0x55 with a one-cycle `tx_valid` -> `dout` low for 8 cycles, then 1,0,1,0,1,0,1,0 at 8 cycles each, then high for 8 cycles; `tx_done` pulses once at cycle 80; `tx_ready` is back at cycle 81.
- `tx_data`=0x00 -> `dout` low for 72 consecutive cycles, then high; total frame 80 cycles.
- `tx_valid` held high with 0xA5 then 0x3C -> two correct frames separated by 9 high cycles; `tx_data` switched to 0xFF mid-frame does not alter the 0xA5 bits.
- Reset asserted at cycle 30 of a 0x0F frame -> `dout`=1, `tx_busy`=0 and `tx_ready`=1 immediately; no `tx_done` pulse; a new 0x81 frame afterwards is correct.
- `UART_TX_PARITY_EN` with 0x07 -> parity bit 1 after bit 7, frame 88 cycles; with 0x03 -> parity bit 0.
- `OVERSAMPLE`=4, `STOP_BITS`=2, 0xC3 -> 4 cycles per bit; stop high for 8 cycles; `tx_done` at cycle 44.
